// File: rtl/my_types_pkg.sv
// my_types_pkg: types shared by the dual-core MIPS pipeline.
//   de_payload_t / em_payload_t / mw_payload_t : fields carried between the
//   decode->execute, execute->memory and memory->writeback stages. Each
//   stage packs its struct into a flat vector and passes DE_W / EM_W / MW_W
//   as DATA_W to its pipe_stage_buf instance.
//   occ_width() : width of an occupancy counter able to hold 0..depth.
package my_types_pkg;

  typedef struct packed {
    logic        core_id;
    logic [31:0] pc;
    logic [5:0]  alu_op;
    logic [4:0]  rd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } de_payload_t;

  typedef struct packed {
    logic        core_id;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_val;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
  } em_payload_t;

  typedef struct packed {
    logic        core_id;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wb_val;
    logic        reg_wr;
  } mw_payload_t;

  localparam int DE_W = $bits(de_payload_t);
  localparam int EM_W = $bits(em_payload_t);
  localparam int MW_W = $bits(mw_payload_t);

  // Counter must represent the full value 'depth', hence the extra bit.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// pipe_buf_mem: DEPTH x W storage for pipe_stage_buf.
//   clk     : write clock
//   wr_en   : write wr_data at wr_addr on the rising edge
//   wr_addr : write address
//   wr_data : word to store
//   rd_addr : read address
//   rd_data : word at rd_addr (combinational read, so the head entry is
//             visible the cycle after it is written)
// Contents are deliberately not reset.
module pipe_buf_mem #(
  parameter int W     = 257,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem_array [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_array[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_array[rd_addr];

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic DEPTH-entry buffer between two pipeline stages.
//   CLK / nRST          : clock, asynchronous active-low reset
//   in_valid/in_ready   : upstream handshake; in_data/in_halt payload
//   out_valid/out_ready : downstream handshake; out_data/out_halt = head
//   flush               : drop every buffered entry (highest priority)
//   occupancy           : entries held (0..DEPTH)
//   halted              : a halt entry was accepted; upstream stays blocked
//                         until reset, or a flush while it is still buffered
//   stall_cnt/flush_cnt : saturating statistics, present only when the
//                         macro PIPE_STAT_EN is defined
// in_ready is a function of registered state only, so there is no
// combinational path from out_ready to in_ready (a full buffer does not
// accept in the same cycle it is popped).
module pipe_stage_buf
  import my_types_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_halt,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_halt,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     halted
`ifdef PIPE_STAT_EN
  ,
  output logic [CNT_W-1:0]         stall_cnt,
  output logic [CNT_W-1:0]         flush_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  if (DATA_W < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1)
  begin : g_param_check
    $error("pipe_stage_buf: illegal DATA_W/DEPTH/CNT_W");
  end

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [OCC_W-1:0] occ_reg;
  logic [OCC_W-1:0] occ_next;
  logic             halted_reg;
  // Tracks whether the halt entry is still in the buffer; halted itself
  // survives the pop, but a flush only clears it while this is set.
  logic             halt_buffered_reg;
  logic [DATA_W:0]  rd_word;
  logic             push;
  logic             pop;

  assign in_ready  = (occ_reg < FULL_OCC) && !halted_reg;
  assign out_valid = (occ_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Forced to zero while empty so the reset value is clean even though the
  // storage itself is never reset.
  assign out_data  = out_valid ? rd_word[DATA_W-1:0] : '0;
  assign out_halt  = out_valid && rd_word[DATA_W];
  assign occupancy = occ_reg;
  assign halted    = halted_reg;

  pipe_buf_mem #(
    .W     (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (CLK),
    .wr_en   (push),
    .wr_addr (wr_ptr_reg),
    .wr_data ({in_halt, in_data}),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_word)
  );

  always_comb begin
    occ_next = occ_reg;
    case ({push, pop})
      2'b10:   occ_next = occ_reg + OCC_W'(1);
      2'b01:   occ_next = occ_reg - OCC_W'(1);
      default: occ_next = occ_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      occ_reg           <= '0;
      halted_reg        <= 1'b0;
      halt_buffered_reg <= 1'b0;
    end else if (flush) begin
      wr_ptr_reg        <= '0;
      rd_ptr_reg        <= '0;
      occ_reg           <= '0;
      halt_buffered_reg <= 1'b0;
      if (halt_buffered_reg) begin
        halted_reg <= 1'b0;
      end
    end else begin
      // Pointers wrap naturally: DEPTH is a power of two.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      occ_reg <= occ_next;
      // Push of a halt and pop of a halt cannot coincide: a buffered halt
      // entry implies halted, which blocks every push.
      if (push && in_halt) begin
        halted_reg        <= 1'b1;
        halt_buffered_reg <= 1'b1;
      end else if (pop && rd_word[DATA_W]) begin
        halt_buffered_reg <= 1'b0;
      end
    end
  end

`ifdef PIPE_STAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_reg != CNT_MAX) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      // Only flushes that actually discarded something are counted.
      if (flush && out_valid && flush_cnt_reg != CNT_MAX) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed, table-driven bench for pipe_stage_buf
// (DATA_W=8, DEPTH=2, CNT_W=4). Statistics checks are compiled only when
// PIPE_STAT_EN is defined.
module tb_pipe_stage_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int OCC_W  = $clog2(DEPTH) + 1;

  logic              CLK = 1'b0;
  logic              nRST = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_halt = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_halt;
  logic              flush = 1'b0;
  logic [OCC_W-1:0]  occupancy;
  logic              halted;
`ifdef PIPE_STAT_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  pipe_stage_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_halt   (in_halt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_halt  (out_halt),
    .flush     (flush),
    .occupancy (occupancy),
    .halted    (halted)
`ifdef PIPE_STAT_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [7:0] d, input logic h,
                        input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_halt   = h;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset between edges and checks the asynchronous effect before
  // the next clock edge arrives.
  task automatic do_reset(input string tag);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    nRST = 1'b0;
    #2;
    chk({tag, "_rst_in_ready"},  in_ready,  1);
    chk({tag, "_rst_out_valid"}, out_valid, 0);
    chk({tag, "_rst_out_data"},  out_data,  0);
    chk({tag, "_rst_out_halt"},  out_halt,  0);
    chk({tag, "_rst_occ"},       occupancy, 0);
    chk({tag, "_rst_halted"},    halted,    0);
`ifdef PIPE_STAT_EN
    chk({tag, "_rst_stall_cnt"}, stall_cnt, 0);
    chk({tag, "_rst_flush_cnt"}, flush_cnt, 0);
`endif
    tick();
    nRST = 1'b1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       eov;
    logic [7:0] eod;
    logic       eir;
    logic [1:0] eocc;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int pushed;
    int popped;

    //            iv    data   ordy  flush  ov    out    ir    occ
    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 2'd1};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[2]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 2'd1};
    vecs[3]  = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 2'd2};
    vecs[4]  = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 2'd2};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 2'd1};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[7]  = '{1'b1, 8'h10, 1'b1, 1'b0, 1'b1, 8'h10, 1'b1, 2'd1};
    vecs[8]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 2'd1};
    vecs[9]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 2'd2};
    vecs[10] = '{1'b1, 8'h07, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[12] = '{1'b1, 8'h30, 1'b0, 1'b0, 1'b1, 8'h30, 1'b1, 2'd1};
    vecs[13] = '{1'b1, 8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
    vecs[15] = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 2'd1};
    vecs[16] = '{1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 2'd2};
    vecs[17] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h21, 1'b1, 2'd1};
    vecs[18] = '{1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 8'h23, 1'b1, 2'd1};
    vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 2'd0};

    #1;
    do_reset("init");

    // Table: basic transfer, fill/backpressure, flush variants, full+pop.
    for (int i = 0; i < 20; i++) begin
      set_in(vecs[i].iv, vecs[i].id, 1'b0, vecs[i].ordy, vecs[i].fl);
      tick();
      $display("vec %0d: iv=%0b id=%0h ordy=%0b fl=%0b -> ov=%0b od=%0h ir=%0b occ=%0d",
               i, vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl,
               out_valid, out_data, in_ready, occupancy);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].eov);
      chk($sformatf("vec%0d_in_ready", i),  in_ready,  vecs[i].eir);
      chk($sformatf("vec%0d_occ", i),       occupancy, vecs[i].eocc);
      chk($sformatf("vec%0d_halted", i),    halted,    0);
      if (vecs[i].eov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].eod);
        chk($sformatf("vec%0d_out_halt", i), out_halt, 0);
      end
    end
`ifdef PIPE_STAT_EN
    chk("table_flush_cnt", flush_cnt, 2);
`endif

    // Streaming: 100 payloads through in 101 cycles, order preserved.
    do_reset("stream");
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 101; c++) begin
      set_in(pushed < 100, 8'(pushed), 1'b0, 1'b1, 1'b0);
      if (out_valid) begin
        chk($sformatf("stream_data_%0d", popped), out_data, 8'(popped));
        popped++;
      end
      if (in_valid && in_ready) pushed++;
      tick();
    end
    $display("stream: pushed=%0d popped=%0d in 101 cycles", pushed, popped);
    chk("stream_pushed", pushed, 100);
    chk("stream_popped", popped, 100);
    chk("stream_occ_end", occupancy, 0);

    // Halt: sticky, survives pop and a later flush, cleared by reset.
    do_reset("halt");
    set_in(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
    tick();
    $display("halt push: halted=%0b ir=%0b ov=%0b oh=%0b od=%0h", halted, in_ready, out_valid, out_halt, out_data);
    chk("halt_halted",   halted,    1);
    chk("halt_in_ready", in_ready,  0);
    chk("halt_out_halt", out_halt,  1);
    chk("halt_out_data", out_data,  8'hFF);
    set_in(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("halt_block_occ_%0d", c), occupancy, 1);
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    tick();
    $display("halt pop: halted=%0b ir=%0b occ=%0d", halted, in_ready, occupancy);
    chk("halt_pop_halted",   halted,    1);
    chk("halt_pop_in_ready", in_ready,  0);
    chk("halt_pop_occ",      occupancy, 0);
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("halt_flush_after_pop_halted", halted, 1);
    do_reset("halt_clear");

    // Flush while the halt entry is still buffered clears halted.
    set_in(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    $display("halt flush: halted=%0b ir=%0b occ=%0d", halted, in_ready, occupancy);
    chk("halt_flush_halted",   halted,    0);
    chk("halt_flush_in_ready", in_ready,  1);
    chk("halt_flush_occ",      occupancy, 0);

    // Asynchronous reset mid-operation with a full buffer.
    set_in(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    tick();
    chk("async_pre_occ", occupancy, 2);
    do_reset("async");

`ifdef PIPE_STAT_EN
    // Stall counter: counts, then saturates at 15.
    set_in(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) tick();
    chk("stall_cnt_10", stall_cnt, 10);
    for (int c = 0; c < 10; c++) tick();
    $display("stall: stall_cnt=%0d after 20 stalled cycles", stall_cnt);
    chk("stall_cnt_sat", stall_cnt, 15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
